// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter fed by a small valid/ready FIFO
//
// Bytes written on the txValid/txReady port are queued in a DEPTH-entry FIFO
// and shifted out LSB first as start bit, 8 data bits and stop bit. Each bit
// lasts CLKS_PER_BIT clocks. Frames from a non-empty FIFO follow each other
// with no idle gap.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high reset
//   txData     byte to enqueue
//   txValid    txData valid this cycle
//   txReady    FIFO can accept; a write happens when txValid & txReady
//   uartTx     registered serial line, idles high
//   busy       high while a frame is being shifted
//   fifoCount  bytes queued in the FIFO (the byte in the shifter is not counted)
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_AW      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         txData,
    input  logic               txValid,
    output logic               txReady,
    output logic               uartTx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifoCount
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [7:0]           mem_q [DEPTH];

    logic push;
    logic pop;
    logic fifo_empty;
    logic bit_done;

    // Ready depends only on the registered count, so there is no
    // combinational path from txValid back to txReady.
    assign txReady    = (count_q != FULL_CNT);
    assign push       = txValid & txReady;
    assign fifo_empty = (count_q == '0);
    assign bit_done   = (clk_cnt_q == CNT_MAX);

    assign uartTx    = tx_q;
    assign busy      = (state_q != S_IDLE);
    assign fifoCount = count_q;

    // tx_d is the line value for the cycle after the edge, which keeps
    // uartTx a plain flop output and lets the start bit begin on the same
    // edge that pops the byte.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    clk_cnt_d = '0;
                    state_d   = S_START;
                    tx_d      = 1'b0;
                end
            end
            S_START: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                    tx_d      = 1'b0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                    tx_d      = shift_q[0];
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    // Chain straight into the next start bit when more data
                    // is waiting, so back-to-back frames have no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                    tx_d      = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= txData;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       reset;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;
    logic       uartTx;
    logic       busy;
    logic [AW:0] fifoCount;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .txData   (txData),
        .txValid  (txValid),
        .txReady  (txReady),
        .uartTx   (uartTx),
        .busy     (busy),
        .fifoCount(fifoCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    // Queue of bytes waiting, plus the number of clocks left in the frame
    // currently on the line. The line value follows from the position in the
    // frame by arithmetic.
    logic [7:0] m_q[$];
    logic [7:0] rx_exp[$];
    logic [7:0] m_cur = 8'h00;
    int         m_left = 0;
    int         m_sz;
    bit         m_pop, m_push;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            rx_exp.delete();
            m_left = 0;
        end else begin
            m_sz   = m_q.size();
            m_pop  = (m_sz != 0) && (m_left <= 1);
            m_push = txValid && (m_sz != DEPTH);
            if (m_pop) begin
                m_cur  = m_q.pop_front();
                rx_exp.push_back(m_cur);
                m_left = FRAME;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
            end
            if (m_push) m_q.push_back(txData);
        end
    end

    function automatic logic exp_line();
        int pos, b;
        if (m_left == 0) return 1'b1;
        pos = FRAME - m_left;
        b   = pos / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            chk("uartTx", {31'd0, uartTx}, {31'd0, exp_line()});
            chk("busy", {31'd0, busy}, {31'd0, (m_left != 0)});
            chk("txReady", {31'd0, txReady}, {31'd0, (m_q.size() != DEPTH)});
            chk("fifoCount", {28'd0, fifoCount}, m_q.size());
        end
    end

    // ---------------- independent line receiver ----------------
    int         rx_t = 0;
    logic [9:0] rx_bits;
    bit         rx_abort = 1'b0;

    always @(posedge clk) if (reset) rx_abort = 1'b1;

    always @(negedge clk) begin
        if (!check_en || rx_abort) begin
            rx_t     = 0;
            rx_abort = 1'b0;
        end else if (rx_t == 0) begin
            if (uartTx == 1'b0) rx_t = 1;
        end else begin
            rx_t++;
            if ((rx_t - 2) % CPB == 0) begin
                rx_bits[(rx_t-2)/CPB] = uartTx;
                if ((rx_t - 2) / CPB == 9) begin
                    chk("rx_start", {31'd0, rx_bits[0]}, 0);
                    chk("rx_stop", {31'd0, rx_bits[9]}, 1);
                    if (rx_exp.size() == 0) fail_now("rx_unexpected_byte");
                    else chk("rx_byte", {24'd0, rx_bits[8:1]}, {24'd0, rx_exp.pop_front()});
                    rx_t = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 = start bit, bit 9 = stop bit
    } vec_t;
    vec_t vt[6];

    task automatic wait_idle();
        int cyc = 0;
        while ((m_q.size() != 0 || m_left != 0) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) fail_now("wait_idle");
        @(negedge clk);
    endtask

    task automatic send_and_check(input logic [7:0] d, input logic [9:0] fr);
        @(negedge clk);
        txValid = 1'b1;
        txData  = d;
        @(negedge clk);
        txValid = 1'b0;
        chk("lat_count", {28'd0, fifoCount}, 1);
        chk("lat_line_high", {31'd0, uartTx}, 1);
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("start_edge", {31'd0, uartTx}, 0);
                chk("popped_count", {28'd0, fifoCount}, 0);
            end
            if ((k - 1) % CPB == 1) chk("frame_bit", {31'd0, uartTx}, {31'd0, fr[(k-1)/CPB]});
            if (k == FRAME) chk("busy_in_stop", {31'd0, busy}, 1);
        end
        @(negedge clk);
        chk("busy_done", {31'd0, busy}, 0);
        chk("line_done", {31'd0, uartTx}, 1);
    endtask

    initial begin
        logic [9:0] fr;
        logic [7:0] bytes10[10];
        int idx, cyc, f, bt;
        bit rdy, stalled;

        vt[0] = '{8'h55, 10'b1010101010};
        vt[1] = '{8'hA3, 10'b1101000110};
        vt[2] = '{8'h0F, 10'b1000011110};
        vt[3] = '{8'hFF, 10'b1111111110};
        vt[4] = '{8'h00, 10'b1000000000};
        vt[5] = '{8'h81, 10'b1100000010};

        reset   = 1'b1;
        txValid = 1'b0;
        txData  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // 1: idle after reset
        repeat (50) @(negedge clk);
        chk("idle_line", {31'd0, uartTx}, 1);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_ready", {31'd0, txReady}, 1);
        chk("idle_count", {28'd0, fifoCount}, 0);

        // 2: single frames from the table
        for (int i = 0; i < 6; i++) begin
            send_and_check(vt[i].data, vt[i].frame);
            repeat (3) @(negedge clk);
        end

        // 3: three contiguous frames
        wait_idle();
        @(negedge clk); txValid = 1'b1; txData = 8'hA3;
        @(negedge clk); txData = 8'h0F;
        @(negedge clk); txData = 8'hFF;
        @(negedge clk); txValid = 1'b0;
        for (int k = 2; k <= 3 * FRAME + 1; k++) begin
            if (k > 2) @(negedge clk);
            if (k <= 3 * FRAME) begin
                f  = (k - 1) / FRAME;
                bt = ((k - 1) % FRAME) / CPB;
                fr = vt[1+f].frame;
                chk("b2b_busy", {31'd0, busy}, 1);
                chk("b2b_line", {31'd0, uartTx}, {31'd0, fr[bt]});
            end else begin
                chk("b2b_done", {31'd0, busy}, 0);
            end
        end

        // 4: overfill with txValid held high
        wait_idle();
        for (int i = 0; i < 10; i++) bytes10[i] = 8'(8'h10 + 8'(i * 7));
        idx = 0; cyc = 0; stalled = 1'b0;
        while (idx < 10 && cyc < 3000) begin
            txValid = 1'b1;
            txData  = bytes10[idx];
            rdy     = txReady;
            if (!rdy && !stalled) begin
                stalled = 1'b1;
                chk("first_stall_idx", idx, 9);
                chk("full_count", {28'd0, fifoCount}, 8);
                chk("full_busy", {31'd0, busy}, 1);
            end
            @(negedge clk);
            cyc++;
            if (rdy) idx++;
        end
        txValid = 1'b0;
        if (idx < 10) fail_now("overfill_accept");
        chk("saw_full", {31'd0, stalled}, 1);
        wait_idle();

        // 5: push and pop on the same edge
        @(negedge clk); txValid = 1'b1; txData = 8'h11;
        @(negedge clk); txData = 8'h22;
        @(negedge clk); txData = 8'h33;
        @(negedge clk); txValid = 1'b0;
        cyc = 0;
        while (m_left != 1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) fail_now("stop_end_wait");
        chk("pre_simul_count", {28'd0, fifoCount}, 2);
        txValid = 1'b1; txData = 8'h3C;
        @(negedge clk);
        txValid = 1'b0;
        chk("simul_count", {28'd0, fifoCount}, 2);
        chk("simul_start", {31'd0, uartTx}, 0);
        wait_idle();

        // 6: reset in the middle of a frame
        @(negedge clk); txValid = 1'b1; txData = 8'h00;
        @(negedge clk); txData = 8'h5A;
        @(negedge clk); txData = 8'hC3;
        @(negedge clk); txValid = 1'b0;
        repeat (13) @(negedge clk);
        chk("mid_line", {31'd0, uartTx}, 0);
        chk("mid_count", {28'd0, fifoCount}, 2);
        reset = 1'b1; txValid = 1'b1; txData = 8'h77;
        @(negedge clk);
        reset = 1'b0; txValid = 1'b0;
        chk("rst_line", {31'd0, uartTx}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_count", {28'd0, fifoCount}, 0);
        chk("rst_ready", {31'd0, txReady}, 1);
        @(negedge clk);
        chk("rst_write_dropped", {28'd0, fifoCount}, 0);
        send_and_check(vt[5].data, vt[5].frame);

        // random traffic against the model
        wait_idle();
        for (int i = 0; i < 600; i++) begin
            txValid = ($urandom_range(0, 2) == 0);
            txData  = 8'($urandom);
            @(negedge clk);
        end
        txValid = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        chk("all_received", rx_exp.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
